// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decode-side inputs and per-stage outputs
// of the post-decode control pipeline.
interface ctrl_pipe_if #(
  parameter int CTRL_W = 16,
  parameter int STAGES = 3
);
  logic [CTRL_W-1:0]        d_ctrl;
  logic                     d_valid;
  logic                     d_multi;
  logic [STAGES-1:0]        stall;
  logic [STAGES-1:0]        flush;
  logic                     mc_done;
  logic [STAGES*CTRL_W-1:0] ctrl_q;
  logic [STAGES-1:0]        valid_q;
  logic                     mc_start;
  logic                     stall_d;

  modport master (
    output d_ctrl, d_valid, d_multi,
    output stall, flush, mc_done,
    input  ctrl_q, valid_q,
    input  mc_start, stall_d
  );

  modport slave (
    input  d_ctrl, d_valid, d_multi,
    input  stall, flush, mc_done,
    output ctrl_q, valid_q,
    output mc_start, stall_d
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: post-decode control pipeline with per-stage
// stall/flush and a multi-cycle execute launch FSM.
module ctrl_pipe #(
  parameter int CTRL_W = 16,
  parameter int STAGES = 3
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mcState_t;

  mcState_t state;

  logic [STAGES-1:0]             valid;
  logic [STAGES-1:0]             multi;
  logic [STAGES-1:0][CTRL_W-1:0] ctrl;

  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             upHold;
  logic [STAGES-1:0]             srcV;
  logic [STAGES-1:0]             srcM;
  logic [STAGES-1:0][CTRL_W-1:0] srcC;

  logic launch;
  logic mcHold;

  // Launch only a real multi-cycle op that is not being flushed.
  always_comb begin
    launch = (state == IDLE) & valid[0] & multi[0]
           & ~bus.flush[0];
    mcHold = launch | (state == BUSY);
  end

  // A stall anywhere downstream backs up every upstream stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_hold
    if (k == 0) begin : g_ex
      assign hold[k] = (|bus.stall[STAGES-1:k]) | mcHold;
    end else begin : g_up
      assign hold[k] = |bus.stall[STAGES-1:k];
    end
  end

  // Stage sources; decode bubbles are forced to all-zero.
  always_comb begin
    srcV    = '0;
    srcM    = '0;
    srcC    = '0;
    upHold  = '0;
    srcV[0] = bus.d_valid;
    srcM[0] = bus.d_valid & bus.d_multi;
    srcC[0] = bus.d_valid ? bus.d_ctrl : '0;
    for (int k = 1; k < STAGES; k++) begin
      srcV[k]   = valid[k-1];
      srcM[k]   = multi[k-1];
      srcC[k]   = ctrl[k-1];
      upHold[k] = hold[k-1];
    end
  end

  // Stage registers: flush, then hold, then bubble, then load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      multi <= '0;
      ctrl  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (bus.flush[k] || (!hold[k] && upHold[k])) begin
          valid[k] <= 1'b0;
          multi[k] <= 1'b0;
          ctrl[k]  <= '0;
        end else if (!hold[k]) begin
          valid[k] <= srcV[k];
          multi[k] <= srcM[k];
          ctrl[k]  <= srcC[k];
        end
      end
    end
  end

  // Multi-cycle unit sequencing; DONE waits for stage 0 to move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (launch) state <= BUSY;
        BUSY: begin
          if (bus.flush[0])     state <= IDLE;
          else if (bus.mc_done) state <= DONE;
        end
        DONE: begin
          if (!hold[0] || bus.flush[0]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ctrl_q   = ctrl;
  assign bus.valid_q  = valid;
  assign bus.mc_start = launch & rst;
  assign bus.stall_d  = hold[0] & rst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vector table plus hand sequences
// for abort, DONE-stall and asynchronous reset.
module tb_ctrl_pipe;

  localparam int W = 16;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ctrl_pipe_if #(.CTRL_W(W), .STAGES(S)) bus ();

  ctrl_pipe #(.CTRL_W(W), .STAGES(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] dc;
    logic        dv;
    logic        dm;
    logic [2:0]  st;
    logic [2:0]  fl;
    logic        md;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [2:0]  vq;
    logic        ms;
    logic        sd;
  } vec_t;

  vec_t tbl[$];
  vec_t seq[$];
  vec_t zv;

  function automatic vec_t mk(
    logic [15:0] dc, logic dv, logic dm,
    logic [2:0] st, logic [2:0] fl, logic md,
    logic [15:0] s0, logic [15:0] s1, logic [15:0] s2,
    logic [2:0] vq, logic ms, logic sd
  );
    vec_t v;
    v.dc = dc; v.dv = dv; v.dm = dm;
    v.st = st; v.fl = fl; v.md = md;
    v.s0 = s0; v.s1 = s1; v.s2 = s2;
    v.vq = vq; v.ms = ms; v.sd = sd;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.d_ctrl  = v.dc;
    bus.d_valid = v.dv;
    bus.d_multi = v.dm;
    bus.stall   = v.st;
    bus.flush   = v.fl;
    bus.mc_done = v.md;
  endtask

  task automatic checkOut(vec_t v, string tag);
    logic [47:0] ec;
    ec = {v.s2, v.s1, v.s0};
    chk({tag, " ctrl_q"}, 64'(bus.ctrl_q), 64'(ec));
    chk({tag, " valid_q"}, 64'(bus.valid_q), 64'(v.vq));
    chk({tag, " mc_start"}, 64'(bus.mc_start), 64'(v.ms));
    chk({tag, " stall_d"}, 64'(bus.stall_d), 64'(v.sd));
  endtask

  task automatic step(vec_t v, string tag);
    @(negedge clk);
    drive(v);
    #1;
    checkOut(v, tag);
  endtask

  initial begin
    zv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0);

    // stream, mid-hold, flush priority, bubble gating
    tbl.push_back(mk(16'h01,1,0,3'b000,3'b000,0, 16'h00,16'h00,16'h00,3'b000,0,0));
    tbl.push_back(mk(16'h02,1,0,3'b000,3'b000,0, 16'h01,16'h00,16'h00,3'b001,0,0));
    tbl.push_back(mk(16'h03,1,0,3'b000,3'b000,0, 16'h02,16'h01,16'h00,3'b011,0,0));
    tbl.push_back(mk(16'h04,1,0,3'b000,3'b000,0, 16'h03,16'h02,16'h01,3'b111,0,0));
    tbl.push_back(mk(16'h05,1,0,3'b010,3'b000,0, 16'h04,16'h03,16'h02,3'b111,0,1));
    tbl.push_back(mk(16'h05,1,0,3'b010,3'b000,0, 16'h04,16'h03,16'h00,3'b011,0,1));
    tbl.push_back(mk(16'h05,1,0,3'b000,3'b000,0, 16'h04,16'h03,16'h00,3'b011,0,0));
    tbl.push_back(mk(16'h06,1,0,3'b000,3'b000,0, 16'h05,16'h04,16'h03,3'b111,0,0));
    tbl.push_back(mk(16'h07,1,0,3'b001,3'b001,0, 16'h06,16'h05,16'h04,3'b111,0,1));
    tbl.push_back(mk(16'h07,1,0,3'b000,3'b000,0, 16'h00,16'h00,16'h05,3'b100,0,0));
    tbl.push_back(mk(16'hFF,0,1,3'b000,3'b000,0, 16'h07,16'h00,16'h00,3'b001,0,0));
    tbl.push_back(mk(16'h00,0,0,3'b000,3'b000,0, 16'h00,16'h07,16'h00,3'b010,0,0));
    tbl.push_back(mk(16'h00,0,0,3'b000,3'b000,0, 16'h00,16'h00,16'h07,3'b100,0,0));
    // multi-cycle op, mc_done 4 cycles after mc_start
    tbl.push_back(mk(16'h0A,1,1,3'b000,3'b000,0, 16'h00,16'h00,16'h00,3'b000,0,0));
    tbl.push_back(mk(16'h0B,1,0,3'b000,3'b000,0, 16'h0A,16'h00,16'h00,3'b001,1,1));
    tbl.push_back(mk(16'h0B,1,0,3'b000,3'b000,0, 16'h0A,16'h00,16'h00,3'b001,0,1));
    tbl.push_back(mk(16'h0B,1,0,3'b000,3'b000,0, 16'h0A,16'h00,16'h00,3'b001,0,1));
    tbl.push_back(mk(16'h0B,1,0,3'b000,3'b000,0, 16'h0A,16'h00,16'h00,3'b001,0,1));
    tbl.push_back(mk(16'h0B,1,0,3'b000,3'b000,1, 16'h0A,16'h00,16'h00,3'b001,0,1));
    tbl.push_back(mk(16'h0B,1,0,3'b000,3'b000,0, 16'h0A,16'h00,16'h00,3'b001,0,0));
    tbl.push_back(mk(16'h00,0,0,3'b000,3'b000,1, 16'h0B,16'h0A,16'h00,3'b011,0,0));
    // back-to-back multi-cycle ops
    tbl.push_back(mk(16'h0C,1,1,3'b000,3'b000,0, 16'h00,16'h0B,16'h0A,3'b110,0,0));
    tbl.push_back(mk(16'h0D,1,1,3'b000,3'b000,0, 16'h0C,16'h00,16'h0B,3'b101,1,1));
    tbl.push_back(mk(16'h0D,1,1,3'b000,3'b000,1, 16'h0C,16'h00,16'h00,3'b001,0,1));
    tbl.push_back(mk(16'h0D,1,1,3'b000,3'b000,0, 16'h0C,16'h00,16'h00,3'b001,0,0));
    tbl.push_back(mk(16'h00,0,0,3'b000,3'b000,0, 16'h0D,16'h0C,16'h00,3'b011,1,1));
    tbl.push_back(mk(16'h00,0,0,3'b000,3'b000,1, 16'h0D,16'h00,16'h0C,3'b101,0,1));
    tbl.push_back(mk(16'h00,0,0,3'b000,3'b000,0, 16'h0D,16'h00,16'h00,3'b001,0,0));
    tbl.push_back(mk(16'h00,0,0,3'b000,3'b000,0, 16'h00,16'h0D,16'h00,3'b010,0,0));

    // reset state with active-looking inputs
    drive(mk(16'hBEEF,1,1,3'b111,3'b000,1, 0,0,0,3'b000,0,0));
    @(negedge clk);
    #1;
    checkOut(zv, "reset");
    drive(zv);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // abort in BUSY, then DONE held by stall[0]
    seq.push_back(mk(16'h10,1,1,3'b000,3'b000,0, 16'h00,16'h00,16'h0D,3'b100,0,0));
    seq.push_back(mk(16'h11,1,0,3'b000,3'b000,0, 16'h10,16'h00,16'h00,3'b001,1,1));
    seq.push_back(mk(16'h11,1,0,3'b000,3'b001,0, 16'h10,16'h00,16'h00,3'b001,0,1));
    seq.push_back(mk(16'h11,1,0,3'b000,3'b000,0, 16'h00,16'h00,16'h00,3'b000,0,0));
    seq.push_back(mk(16'h12,1,1,3'b000,3'b000,0, 16'h11,16'h00,16'h00,3'b001,0,0));
    seq.push_back(mk(16'h13,1,0,3'b000,3'b000,0, 16'h12,16'h11,16'h00,3'b011,1,1));
    seq.push_back(mk(16'h13,1,0,3'b000,3'b000,1, 16'h12,16'h00,16'h11,3'b101,0,1));
    seq.push_back(mk(16'h13,1,0,3'b001,3'b000,0, 16'h12,16'h00,16'h00,3'b001,0,1));
    seq.push_back(mk(16'h13,1,0,3'b001,3'b000,1, 16'h12,16'h00,16'h00,3'b001,0,1));
    seq.push_back(mk(16'h13,1,0,3'b001,3'b000,0, 16'h12,16'h00,16'h00,3'b001,0,1));
    seq.push_back(mk(16'h13,1,0,3'b000,3'b000,0, 16'h12,16'h00,16'h00,3'b001,0,0));
    seq.push_back(mk(16'h00,0,0,3'b000,3'b000,0, 16'h13,16'h12,16'h00,3'b011,0,0));
    seq.push_back(mk(16'h00,0,0,3'b000,3'b000,0, 16'h00,16'h13,16'h12,3'b110,0,0));
    for (int i = 0; i < seq.size(); i++)
      step(seq[i], $sformatf("abort%0d", i));

    // async reset in the middle of BUSY
    step(mk(16'h20,1,1,3'b000,3'b000,0, 16'h00,16'h00,16'h13,3'b100,0,0), "rst0");
    step(mk(16'h21,1,0,3'b000,3'b000,0, 16'h20,16'h00,16'h00,3'b001,1,1), "rst1");
    step(mk(16'h21,1,0,3'b010,3'b000,0, 16'h20,16'h00,16'h00,3'b001,0,1), "rst2");
    #2;
    rst = 1'b0;
    #1;
    checkOut(zv, "rstmid");
    @(negedge clk);
    rst = 1'b1;
    drive(mk(16'h22,1,1,3'b000,3'b000,0, 0,0,0,3'b000,0,0));
    #1;
    checkOut(zv, "rstrel");
    step(mk(16'h00,0,0,3'b000,3'b000,0, 16'h22,16'h00,16'h00,3'b001,1,1), "rst4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
